// File: rtl/stereo_i2s_tx_pkg.sv
// Shared audio definitions for the I2S transmitter: sample/frame geometry,
// word-select levels and the slot-to-LRCLK mapping.
package stereo_i2s_tx_pkg;

    localparam int SAMPLE_W    = 16;
    localparam int FRAME_BITS  = 2 * SAMPLE_W;
    localparam int CNT_W       = $clog2(FRAME_BITS);

    localparam logic LR_LEFT   = 1'b0;
    localparam logic LR_RIGHT  = 1'b1;

    localparam int LR_RISE_BIT = SAMPLE_W - 1;
    localparam int LR_FALL_BIT = FRAME_BITS - 1;

    typedef logic [CNT_W-1:0] bit_cnt_t;

    // Word select runs one BCLK ahead of the data, so the right slot spans
    // counts 15..30 and the left slot wraps around through 31.
    function automatic logic slot_lr(input bit_cnt_t k);
        if ((k >= bit_cnt_t'(LR_RISE_BIT)) && (k < bit_cnt_t'(LR_FALL_BIT)))
            return LR_RIGHT;
        return LR_LEFT;
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit-clock generator: divides the system clock down to BCLK and flags the
// system-clock cycle in which BCLK falls.
module i2s_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic bclk,
    output logic fall_evt
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             terminal;

    assign terminal = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign fall_evt = enable && terminal && bclk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (!enable) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (terminal) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/stereo_i2s_tx.sv
// Stereo I2S (Philips) transmitter: double-buffers one L/R pair, serialises
// it MSB first on falling BCLK, and reports frame requests and underruns.
module stereo_i2s_tx
    import stereo_i2s_tx_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample_l,
    input  logic [SAMPLE_W-1:0] sample_r,
    input  logic                sample_valid,
    output logic                frame_req,
    output logic                underrun,
    input  logic                clear_underrun,
    output logic                bclk,
    output logic                lrclk,
    output logic                sdata
);

    localparam int IDX_W = CNT_W - 1;

    logic                fall_evt;
    logic                load;
    logic                fresh;
    bit_cnt_t            bit_cnt;
    bit_cnt_t            bit_nxt;
    logic [IDX_W-1:0]    slot_idx;
    logic [SAMPLE_W-1:0] hold_l, hold_r;
    logic [SAMPLE_W-1:0] left_shift, right_shift;
    logic [SAMPLE_W-1:0] load_l, load_r;

    i2s_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .bclk     (bclk),
        .fall_evt (fall_evt)
    );

    assign bit_nxt  = bit_cnt + 1'b1;
    assign load     = fall_evt && (bit_cnt == bit_cnt_t'(LR_FALL_BIT));
    assign slot_idx = ~bit_nxt[IDX_W-1:0];

    // A sample arriving in the load cycle goes straight into this frame.
    assign load_l = sample_valid ? sample_l : hold_l;
    assign load_r = sample_valid ? sample_r : hold_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_l <= '0;
            hold_r <= '0;
        end else if (sample_valid) begin
            hold_l <= sample_l;
            hold_r <= sample_r;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fresh     <= 1'b0;
            underrun  <= 1'b0;
            frame_req <= 1'b0;
        end else begin
            frame_req <= load;
            if (load)
                fresh <= 1'b0;
            else if (sample_valid)
                fresh <= 1'b1;
            if (load && !fresh && !sample_valid)
                underrun <= 1'b1;
            else if (clear_underrun)
                underrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            left_shift  <= '0;
            right_shift <= '0;
        end else if (load) begin
            left_shift  <= load_l;
            right_shift <= load_r;
        end
    end

    // Counter, data and word select all advance on the falling BCLK event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= bit_cnt_t'(LR_FALL_BIT);
            lrclk   <= LR_LEFT;
            sdata   <= 1'b0;
        end else if (!enable) begin
            bit_cnt <= bit_cnt_t'(LR_FALL_BIT);
            lrclk   <= LR_LEFT;
            sdata   <= 1'b0;
        end else if (fall_evt) begin
            bit_cnt <= bit_nxt;
            lrclk   <= slot_lr(bit_nxt);
            if (load)
                sdata <= load_l[SAMPLE_W-1];
            else if (bit_nxt[CNT_W-1])
                sdata <= right_shift[slot_idx];
            else
                sdata <= left_shift[slot_idx];
        end
    end

endmodule

// File: tb/tb_stereo_i2s_tx.sv
// Self-checking bench for stereo_i2s_tx: table-driven sample frames checked
// by a serial-capture scoreboard, plus bypass, enable and reset sequences.
module tb_stereo_i2s_tx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [15:0] sample_l, sample_r;
    logic        sample_valid;
    logic        clear_underrun;
    logic        frame_req, underrun, bclk, lrclk, sdata;

    stereo_i2s_tx #(.CLK_DIV(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .sample_l       (sample_l),
        .sample_r       (sample_r),
        .sample_valid   (sample_valid),
        .frame_req      (frame_req),
        .underrun       (underrun),
        .clear_underrun (clear_underrun),
        .bclk           (bclk),
        .lrclk          (lrclk),
        .sdata          (sdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] l1, r1, l2, r2;
        bit          dbl;
        logic [15:0] exp_l, exp_r;
    } vec_t;

    typedef struct {
        logic [15:0] l, r;
    } frame_t;

    frame_t exp_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Serial capture: one word per frame, taken on rising BCLK as the DAC does.
    logic        mon_on = 1'b1;
    bit          cap_active = 1'b0;
    int          cap_n = 0;
    logic [31:0] cap_d, cap_lr;
    frame_t      cur;
    logic        bclk_prev = 1'b0;

    always @(negedge clk) begin
        if (!reset_n || !enable) begin
            cap_active = 1'b0;
            cap_n      = 0;
        end else begin
            if (cap_active && bclk && !bclk_prev) begin
                cap_d  = {cap_d[30:0], sdata};
                cap_lr = {cap_lr[30:0], lrclk};
                cap_n++;
                if (cap_n == 32) begin
                    check("frame_data", cap_d, {cur.l, cur.r});
                    check("frame_lrclk", cap_lr, 32'h0001_FFFE);
                    cap_active = 1'b0;
                end
            end
            if (frame_req && mon_on) begin
                if (exp_q.size() == 0) begin
                    check("sb_queue_size", 32'(exp_q.size()), 32'd1);
                end else begin
                    cur        = exp_q.pop_front();
                    cap_active = 1'b1;
                    cap_n      = 0;
                    cap_d      = '0;
                    cap_lr     = '0;
                end
            end
        end
        bclk_prev = bclk;
    end

    task automatic wait_load(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_req && n < 400);
        if (!frame_req) check("load_timeout", 32'(frame_req), 32'd1);
    endtask

    task automatic wait_bclk_rise(output time t);
        logic prev;
        int   k;
        prev = bclk;
        t    = 0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bclk && !prev) begin
                t = $time;
                break;
            end
            prev = bclk;
        end
        if (k == 20) check("bclk_timeout", 32'(bclk), 32'd1);
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        sample_l     = l;
        sample_r     = r;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    initial begin
        vec_t vecs[5];
        int   n;
        time  t1, t2;

        vecs[0] = '{16'hA5C3, 16'h3C5A, 16'h0000, 16'h0000, 1'b0, 16'hA5C3, 16'h3C5A};
        vecs[1] = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 16'h0000};
        vecs[2] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b1, 16'h3333, 16'h4444};
        vecs[3] = '{16'h0001, 16'h8000, 16'h0000, 16'h0000, 1'b0, 16'h0001, 16'h8000};
        vecs[4] = '{16'h7FFF, 16'h8001, 16'h0000, 16'h0000, 1'b0, 16'h7FFF, 16'h8001};

        reset_n        = 1'b0;
        enable         = 1'b0;
        sample_l       = '0;
        sample_r       = '0;
        sample_valid   = 1'b0;
        clear_underrun = 1'b0;
        exp_q.push_back('{16'h0000, 16'h0000});

        // Reset state, first load latency, bclk period
        repeat (2) @(negedge clk);
        check("rst_bclk", 32'(bclk), 32'd0);
        check("rst_lrclk", 32'(lrclk), 32'd0);
        check("rst_sdata", 32'(sdata), 32'd0);
        check("rst_frame_req", 32'(frame_req), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        reset_n = 1'b1;
        enable  = 1'b1;
        wait_load(n);
        check("first_load_latency", 32'(n), 32'd8);
        check("first_load_underrun", 32'(underrun), 32'd1);
        @(negedge clk);
        check("frame_req_pulse", 32'(frame_req), 32'd0);
        wait_bclk_rise(t1);
        wait_bclk_rise(t2);
        check("bclk_period", 32'(t2 - t1), 32'd80);

        clear_underrun = 1'b1;
        @(negedge clk);
        clear_underrun = 1'b0;
        check("underrun_cleared", 32'(underrun), 32'd0);

        // Table of frames, including two valids within one frame
        for (int i = 0; i < 5; i++) begin
            repeat (20) @(negedge clk);
            send(vecs[i].l1, vecs[i].r1);
            if (vecs[i].dbl) begin
                repeat (10) @(negedge clk);
                send(vecs[i].l2, vecs[i].r2);
            end
            exp_q.push_back('{vecs[i].exp_l, vecs[i].exp_r});
            wait_load(n);
            check("vec_underrun", 32'(underrun), 32'd0);
        end

        // Valid in the exact load cycle bypasses into the frame
        exp_q.push_back('{16'h8001, 16'h7FFE});
        repeat (255) @(negedge clk);
        send(16'h8001, 16'h7FFE);
        check("bypass_frame_req", 32'(frame_req), 32'd1);
        check("bypass_underrun", 32'(underrun), 32'd0);
        exp_q.push_back('{16'h8001, 16'h7FFE});
        wait_load(n);
        check("repeat_underrun", 32'(underrun), 32'd1);

        // Enable dropped mid-frame at bit_cnt 9 while bclk and sdata are high
        repeat (20) @(negedge clk);
        send(16'hFFFF, 16'hFFFF);
        exp_q.push_back('{16'hFFFF, 16'hFFFF});
        wait_load(n);
        repeat (77) @(negedge clk);
        check("pre_disable_bclk", 32'(bclk), 32'd1);
        check("pre_disable_sdata", 32'(sdata), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        check("dis_bclk", 32'(bclk), 32'd0);
        check("dis_lrclk", 32'(lrclk), 32'd0);
        check("dis_sdata", 32'(sdata), 32'd0);
        check("dis_underrun_kept", 32'(underrun), 32'd1);
        send(16'h5A5A, 16'h0F0F);
        exp_q.push_back('{16'h5A5A, 16'h0F0F});
        repeat (3) @(negedge clk);
        enable = 1'b1;
        wait_load(n);
        check("reenable_latency", 32'(n), 32'd8);
        check("reenable_underrun_sticky", 32'(underrun), 32'd1);
        exp_q.push_back('{16'h5A5A, 16'h0F0F});
        wait_load(n);

        // Asynchronous reset mid-frame, away from any clock edge
        repeat (38) @(negedge clk);
        check("pre_reset_bclk", 32'(bclk), 32'd1);
        check("pre_reset_sdata", 32'(sdata), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_bclk", 32'(bclk), 32'd0);
        check("async_sdata", 32'(sdata), 32'd0);
        check("async_lrclk", 32'(lrclk), 32'd0);
        check("async_underrun", 32'(underrun), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.push_back('{16'h0000, 16'h0000});
        wait_load(n);
        check("post_reset_latency", 32'(n), 32'd8);
        check("post_reset_underrun", 32'(underrun), 32'd1);
        repeat (254) @(negedge clk);
        mon_on = 1'b0;
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        check("last_frame_done", 32'(cap_active), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stereo_i2s_tx.md
Name: stereo_i2s_tx

Overview:
- Downstream of the stereo conditioner. Takes the 16-bit left/right mix plus a per-sample strobe and serialises it as standard I2S (Philips) to the board audio DAC.
- Double-buffers one stereo pair and generates BCLK/LRCLK from the system clock.
- Raises a frame request each frame and flags underrun when no fresh sample arrived in time.

Parameters:
- CLK_DIV, 4, system clocks per BCLK half-period (min 2)
- SAMPLE_W, 16, bits per channel; frame is 2*SAMPLE_W BCLKs

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  run serialiser; low = idle
- sample_l  in  16  left sample, two's complement, from stereo conditioner
- sample_r  in  16  right sample
- sample_valid  in  1  one-clk strobe: capture sample_l/sample_r
- frame_req  out  1  one-clk pulse when a frame is loaded into the shifter
- underrun  out  1  sticky: a frame was loaded with no new sample since the previous load
- clear_underrun  in  1  synchronous clear of underrun
- bclk  out  1  bit clock
- lrclk  out  1  word select, 0 = left
- sdata  out  1  serial data, MSB first

Behaviour:
- Reset (async, reset_n low), all values:
  - bclk=0, lrclk=0, sdata=0, frame_req=0, underrun=0.
  - bit_cnt=2*SAMPLE_W-1 (31), div_cnt=0.
  - Holding regs=0, shifter=0, fresh flag=0.
- Clock divider:
  - div_cnt counts 0..CLK_DIV-1 while enable is high.
  - At terminal count, bclk toggles and div_cnt returns to 0.
- Falling BCLK event: the clk cycle in which bclk toggles 1->0. On this event:
  - bit_cnt increments, modulo 32.
  - sdata and lrclk update in the same cycle.
- Rising edges carry no logic; the DAC samples there.
- Slot map, by new bit_cnt k:
  - k=0..15: sdata=left_shift[15-k].
  - k=16..31: sdata=right_shift[31-k].
  - lrclk=0 for k in {31,0..14}; lrclk=1 for k in {15..30}. LRCLK therefore leads each MSB by one BCLK.
- Holding buffer:
  - On sample_valid, hold_l/hold_r <= sample_l/sample_r and fresh<=1.
  - Multiple valids before a load: the last one wins (no flag).
- Frame load: on the falling event where bit_cnt wraps 31->0:
  - left_shift/right_shift <= hold_l/hold_r.
  - frame_req=1 for that single clk.
  - If fresh==0, underrun<=1; old hold data is repeated.
  - fresh<=0.
- Load and valid in the same clk: the incoming sample bypasses into the shifter and is output this frame. fresh stays 0. No underrun.
- underrun:
  - clear_underrun clears it.
  - If clear and set occur in the same clk, set wins.
- Latency: a sample captured at clk t reaches sdata at the first frame load after t. The MSB of left appears in that load cycle.
- enable low:
  - Finish nothing; in the next clk force the reset state of bclk, lrclk, sdata, bit_cnt and div_cnt.
  - Holding regs and underrun are retained.
  - Re-enable: first falling event occurs after 2*CLK_DIV clks, and loads a frame.
- Arithmetic: bit_cnt is 5 bits and wraps naturally. No arithmetic is performed on sample data; it is passed bit-exact.

Decomposition:
- Shared header (audio_defs.vh) holds:
  - SAMPLE_W and FRAME_BITS (=2*SAMPLE_W).
  - LR_LEFT=0, LR_RIGHT=1.
  - Slot boundaries LR_RISE_BIT=15, LR_FALL_BIT=31.
- One sub-module: i2s_clk_gen.
  - Contains the divider, bclk register and the fall_evt strobe.
  - Parameter CLK_DIV; ports clk, reset_n, enable, bclk, fall_evt.
- Shifter, buffer and flags stay in stereo_i2s_tx.

Test Plan (CLK_DIV=4, BCLK period 8 clk, frame 256 clk):
1. Reset, enable=1, no valids -> first load at clk ~8: frame_req pulses, sdata all 0, underrun=1; bclk period exactly 8 clk.
2. Valid L=0xA5C3, R=0x3C5A before a load -> next frame: sdata bits 0..15 = 1010010111000011, bits 16..31 = 0011110001011010. lrclk low at k=31, high at k=15. underrun unchanged after clear.
3. Valid asserted in the exact load clk with L=0x8001, R=0x7FFE -> that same frame carries 0x8001/0x7FFE; underrun stays 0; next load with no valid sets underrun.
4. Two valids (0x1111/0x2222, then 0x3333/0x4444) within one frame -> next frame carries 0x3333/0x4444 only.
5. enable dropped mid-frame at bit_cnt=9 -> next clk bclk=0, lrclk=0, sdata=0. Re-enable -> first falling event after 8 clk loads a frame and sends a complete frame.
6. reset_n pulsed low mid-frame, asynchronously (not clk-aligned) -> outputs go to reset values without waiting for clk; underrun and holding regs cleared.
